// File: rtl/definitions.sv
// Shared widths and fetch-stage types for the core.
package definitions;
  localparam int P_WIDTH = 8;
  localparam int I_WIDTH = 9;

  typedef enum logic [1:0] {FS_IDLE, FS_RUN, FS_HALTED} fetch_state_t;

  localparam logic [I_WIDTH-1:0] HALT_OPCODE = 9'h1FF;
endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the ROM address, registers the fetched word into IR.
module fetch_unit
  import definitions::*;
#(
  parameter logic [P_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [I_WIDTH-1:0] HALT_INSTR = HALT_OPCODE,
  parameter int                 CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [P_WIDTH-1:0]   branch_target,
  output logic [P_WIDTH-1:0]   rom_addr,
  input  logic [I_WIDTH-1:0]   rom_instr,
  output logic [I_WIDTH-1:0]   ir,
  output logic [P_WIDTH-1:0]   ir_pc,
  output logic                 ir_valid,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  fetch_state_t         r_state, w_state_nxt;
  logic [P_WIDTH-1:0]   r_pc;
  logic [I_WIDTH-1:0]   r_ir;
  logic [P_WIDTH-1:0]   r_ir_pc;
  logic                 r_ir_valid;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic w_run, w_start, w_branch, w_issue, w_halt;

  // Branch wins over stall; start is only honoured outside RUN.
  assign w_run    = (r_state == FS_RUN);
  assign w_start  = start && !w_run;
  assign w_branch = w_run && branch_taken;
  assign w_issue  = w_run && !branch_taken && !stall;
  assign w_halt   = w_issue && (rom_instr == HALT_INSTR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FS_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FS_IDLE:   if (w_start) w_state_nxt = FS_RUN;
      FS_RUN:    if (w_halt)  w_state_nxt = FS_HALTED;
      FS_HALTED: if (w_start) w_state_nxt = FS_RUN;
      default:   w_state_nxt = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
    end else if (w_start) begin
      r_pc       <= RESET_PC;
      r_ir_valid <= 1'b0;
    end else if (w_branch) begin
      // The word fetched this cycle is wrong-path; drop it and refetch at target.
      r_pc       <= branch_target;
      r_ir_valid <= 1'b0;
    end else if (w_issue) begin
      r_ir       <= rom_instr;
      r_ir_pc    <= r_pc;
      r_ir_valid <= 1'b1;
      r_pc       <= r_pc + 1'b1;
    end else if (!w_run) begin
      r_ir_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_cnt <= '0;
    else if (w_start)           r_cnt <= '0;
    else if (w_issue && ~&r_cnt) r_cnt <= r_cnt + 1'b1;
  end

  assign rom_addr    = r_pc;
  assign ir          = r_ir;
  assign ir_pc       = r_ir_pc;
  assign ir_valid    = r_ir_valid;
  assign busy        = (r_state == FS_RUN);
  assign done        = (r_state == FS_HALTED);
  assign fetch_count = r_cnt;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the combinational instruction ROM.
- Owns the program counter and drives the ROM address. Captures the ROM's instruction into a registered instruction register (IR) for decode.
- Handles start, stall, taken-branch redirect with one-bubble flush, and halt detection.
- Exposes run status to the top level and the testbench.

Parameters:
- RESET_PC, default '0 (P_WIDTH bits): PC loaded on reset and on every start.
- HALT_INSTR, default 9'b1_1111_1111 (I_WIDTH bits): instruction encoding that ends the program.
- CNT_WIDTH, default 16: width of the fetched-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins execution at RESET_PC from IDLE or HALTED.
- stall  input  1  hold request from decode/execute; freezes PC and IR.
- branch_taken  input  1  redirect request from execute; valid only in RUN.
- branch_target  input  P_WIDTH  absolute redirect address.
- rom_addr  output  P_WIDTH  ROM address; always equal to the PC register.
- rom_instr  input  I_WIDTH  ROM read data; combinational, same cycle as rom_addr.
- ir  output  I_WIDTH  registered instruction to decode.
- ir_pc  output  P_WIDTH  address the current ir was fetched from.
- ir_valid  output  1  ir holds a live instruction.
- busy  output  1  state == RUN.
- done  output  1  state == HALTED; sticky until start or reset.
- fetch_count  output  CNT_WIDTH  instructions issued since last start; saturates at all-ones.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, pc = RESET_PC.
  - ir = 0, ir_pc = 0, ir_valid = 0.
  - done = 0, busy = 0, fetch_count = 0.
  - Reset mid-run aborts immediately; no pending fetch survives.
- State machine {IDLE, RUN, HALTED}:
  - IDLE --start--> RUN.
  - RUN --issue of HALT_INSTR--> HALTED.
  - HALTED --start--> RUN.
  - start while in RUN is ignored.
- start (IDLE or HALTED): next cycle pc = RESET_PC, ir_valid = 0, fetch_count = 0, done = 0. The first instruction issues on the following edge.
- RUN, per rising edge, in priority order:
  1. branch_taken: pc <= branch_target; ir_valid <= 0 (flushes the wrong-path fetch); fetch_count unchanged. Branch overrides stall in the same cycle.
  2. stall: pc, ir, ir_pc, ir_valid and fetch_count all hold.
  3. otherwise: ir <= rom_instr, ir_pc <= pc, ir_valid <= 1, pc <= pc + 1, fetch_count <= fetch_count + 1 (saturating).
- Latency: instruction at address A appears on ir one cycle after rom_addr == A with no stall. Taken branch costs exactly one bubble cycle.
- PC arithmetic: modulo 2^P_WIDTH. The last address increments to 0 with no flag.
- Halt detection:
  - Evaluated only on an issuing edge (case 3 above) with rom_instr == HALT_INSTR.
  - The halt instruction is itself issued (ir_valid = 1 for one cycle); then state = HALTED.
  - On the next edge ir_valid <= 0; pc stays frozen at halt address + 1.
- Not RUN (IDLE or HALTED): branch_taken and stall are ignored; ir_valid = 0; pc holds.
- busy and done are decoded from the state register, so they are glitch-free registered outputs. done rises in the same cycle ir_valid shows the halt instruction.

Decomposition:
- Package definitions (existing) supplies P_WIDTH and I_WIDTH.
- Add to the package:
  - fetch_state_t enum {FS_IDLE, FS_RUN, FS_HALTED}.
  - Constant HALT_OPCODE, which is the default for HALT_INSTR.
- A single module; no sub-module. The saturating counter is an inline always_ff.

Test Plan:
- Reset and start: rst_n low, then high; start pulse; ROM holds 0x001, 0x002, 0x003 at addrs 0..2. Required: rom_addr sequence 0, 1, 2, 3; ir 0x001, 0x002, 0x003 on consecutive cycles after the start+1 edge; ir_pc 0, 1, 2; fetch_count 1, 2, 3.
- Stall: stall high for 3 cycles while rom_addr == 5. Required: ir and ir_pc (4) and fetch_count frozen; rom_addr stays 5; resume issues addr 5 next.
- Branch: branch_taken with target 0x20 while pc == 7, and stall simultaneously high. Required: next cycle ir_valid = 0 and rom_addr = 0x20; one cycle later ir_pc = 0x20.
- Halt: HALT_INSTR at addr 4. Required: ir = HALT_INSTR with ir_valid = 1 and done = 1 in the same cycle; then ir_valid = 0, pc = 5 frozen. branch_taken afterwards has no effect. A second start restarts from RESET_PC with done = 0.
- Wrap: set RESET_PC = all-ones with no halt at that address. Required: the fetch after the top address uses rom_addr = 0.
- Async reset mid-run: drop rst_n between clock edges at pc == 9. Required: outputs return to reset values immediately, without waiting for a clock edge; after release the state is IDLE until start.
